// File: rtl/arb_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM encoding, index widths
// and the round-robin pointer advance.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_t;

    localparam int IDX_W  = 3;
    localparam int HOLD_W = 16;

    // Port 0 never takes part in round-robin, so the pointer cycles 1..n_ports-1.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] k, input int n_ports);
        if (int'(k) >= n_ports - 1) begin
            return IDX_W'(1);
        end
        return k + IDX_W'(1);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_select.sv
// Combinational winner selection: port 0 first, then round-robin over ports
// 1..N_PORTS-1 starting at the pointer, with one optional excluded port.
module rr_select
    import arb_pkg::*;
#(
    parameter int N_PORTS = 3
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic               i_excl_en,
    input  logic [IDX_W-1:0]   i_excl_idx,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_winner
);

    logic [N_PORTS-1:0] w_cand;

    always_comb begin
        int d;
        int bestD;
        w_cand   = i_req;
        o_found  = 1'b0;
        o_winner = '0;
        bestD    = N_PORTS;
        d        = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (i_excl_en && i_excl_idx == IDX_W'(i)) begin
                w_cand[i] = 1'b0;
            end
        end
        if (w_cand[0]) begin
            o_found  = 1'b1;
            o_winner = '0;
        end else begin
            // Distance from the pointer decides priority; the closest requester wins.
            for (int i = 1; i < N_PORTS; i++) begin
                d = (i - int'(i_rr_ptr) + N_PORTS - 1) % (N_PORTS - 1);
                if (w_cand[i] && d < bestD) begin
                    bestD    = d;
                    o_found  = 1'b1;
                    o_winner = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multi-port arbiter in front of a 1-cycle-latency synchronous RAM; port 0 is the
// real-time port, a SETUP bubble re-reads the new owner's last address.
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int N_PORTS  = 3,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int PREEMPT  = 1,
    parameter int HOLD_MAX = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_PORTS-1:0]         req,
    input  logic [N_PORTS*ADDR_W-1:0]  addr,
    input  logic [N_PORTS-1:0]         we,
    input  logic [N_PORTS*DATA_W-1:0]  wdata,
    output logic [N_PORTS-1:0]         ready,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          ram_waddr,
    output logic [ADDR_W-1:0]          ram_raddr,
    output logic [DATA_W-1:0]          ram_wdata,
    output logic                       ram_we,
    input  logic [DATA_W-1:0]          ram_rdata
);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [ADDR_W-1:0]   r_last_addr [N_PORTS];

    arb_state_t          w_state_hold;
    logic                w_arb;
    logic                w_excl_en;
    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic                w_go;
    logic                w_own_req;
    logic                w_own_we;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;
    logic [ADDR_W-1:0]   w_own_last;
    logic [N_PORTS-1:0]  w_own_onehot;
    logic                w_others;

    rr_select #(
        .N_PORTS (N_PORTS)
    ) u_rr_select (
        .i_req      (req),
        .i_rr_ptr   (r_rr_ptr),
        .i_excl_en  (w_excl_en),
        .i_excl_idx (r_owner),
        .o_found    (w_found),
        .o_winner   (w_winner)
    );

    always_comb begin
        w_own_req    = 1'b0;
        w_own_we     = 1'b0;
        w_own_addr   = '0;
        w_own_wdata  = '0;
        w_own_last   = '0;
        w_own_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_req       = req[i];
                w_own_we        = we[i];
                w_own_addr      = addr[i*ADDR_W +: ADDR_W];
                w_own_wdata     = wdata[i*DATA_W +: DATA_W];
                w_own_last      = r_last_addr[i];
                w_own_onehot[i] = 1'b1;
            end
        end
        w_others = |(req & ~w_own_onehot);
    end

    always_comb begin
        w_state_hold = r_state;
        w_arb        = 1'b0;
        w_excl_en    = 1'b0;
        ready        = '0;
        ram_we       = 1'b0;
        ram_raddr    = '0;
        ram_waddr    = '0;
        ram_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                w_arb = |req;
            end
            ST_SETUP: begin
                ram_raddr    = w_own_last;
                w_state_hold = ST_OWN;
            end
            ST_OWN: begin
                ram_raddr = w_own_addr;
                if (!w_own_req) begin
                    w_arb = |req;
                    if (!(|req)) begin
                        w_state_hold = ST_IDLE;
                    end
                end else begin
                    ready     = w_own_onehot;
                    ram_waddr = w_own_addr;
                    ram_wdata = w_own_wdata;
                    ram_we    = w_own_we;
                    if (PREEMPT != 0 && r_owner != '0 && req[0]) begin
                        w_arb = 1'b1;
                    end else if (HOLD_MAX != 0 && r_hold_cnt >= HOLD_W'(HOLD_MAX - 1) && w_others) begin
                        w_arb     = 1'b1;
                        w_excl_en = 1'b1;
                    end
                end
            end
            default: begin
                w_state_hold = ST_IDLE;
            end
        endcase
    end

    assign w_go  = w_arb && w_found;
    assign rdata = ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= IDX_W'(1);
            r_hold_cnt <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_last_addr[i] <= '0;
            end
        end else begin
            r_state <= w_go ? ST_SETUP : w_state_hold;
            // Every SETUP entry passes through here, so the hold counter restarts with each new owner.
            if (w_go) begin
                r_owner    <= w_winner;
                r_hold_cnt <= '0;
                if (w_winner != '0) begin
                    r_rr_ptr <= rr_next(w_winner, N_PORTS);
                end
            end else if (r_state == ST_OWN && r_hold_cnt != '1) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (ready[i]) begin
                    r_last_addr[i] <= addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance with pre-emption and HOLD_MAX=4
// backed by a RAM model, one without pre-emption for the cooperative-release case.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [32:0] addr;
    logic [2:0]  we;
    logic [23:0] wdata;

    logic [2:0]  readyA;
    logic [7:0]  rdataA;
    logic [10:0] ramWaddrA;
    logic [10:0] ramRaddrA;
    logic [7:0]  ramWdataA;
    logic        ramWeA;
    logic [7:0]  ramRdataA;

    logic [2:0]  readyB;
    logic [7:0]  rdataB;
    logic [10:0] ramWaddrB;
    logic [10:0] ramRaddrB;
    logic [7:0]  ramWdataB;
    logic        ramWeB;

    logic [7:0]  memA [0:2047];

    int checkCount = 0;
    int passCount  = 0;
    int weSeen     = 0;

    ram_port_arbiter #(
        .N_PORTS (3), .ADDR_W (11), .DATA_W (8), .PREEMPT (1), .HOLD_MAX (4)
    ) dutA (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .ready     (readyA),
        .rdata     (rdataA),
        .ram_waddr (ramWaddrA),
        .ram_raddr (ramRaddrA),
        .ram_wdata (ramWdataA),
        .ram_we    (ramWeA),
        .ram_rdata (ramRdataA)
    );

    ram_port_arbiter #(
        .N_PORTS (3), .ADDR_W (11), .DATA_W (8), .PREEMPT (0), .HOLD_MAX (0)
    ) dutB (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .ready     (readyB),
        .rdata     (rdataB),
        .ram_waddr (ramWaddrB),
        .ram_raddr (ramRaddrB),
        .ram_wdata (ramWdataB),
        .ram_we    (ramWeB),
        .ram_rdata (8'h00)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] memInit(input int a);
        return 8'((a * 5 + 3) & 255);
    endfunction

    // Synchronous RAM with one cycle of read latency; contents reload while in reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2048; i++) begin
                memA[i] <= memInit(i);
            end
        end else if (ramWeA) begin
            memA[ramWaddrA] <= ramWdataA;
        end
        ramRdataA <= memA[ramRaddrA];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic [10:0] a, input logic w, input logic [7:0] d);
        req[p]             = r;
        addr[p*11 +: 11]   = a;
        we[p]              = w;
        wdata[p*8 +: 8]    = d;
    endtask

    task automatic stepTo();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        req     = '0;
        we      = '0;
        stepTo();
        stepTo();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] expReady;
        reset_n = 1'b0;
        req     = '0;
        addr    = '0;
        we      = '0;
        wdata   = '0;

        stepTo();
        checkOutput("reset ready", 32'(readyA), 32'h0);
        checkOutput("reset we", 32'(ramWeA), 32'h0);
        checkOutput("reset raddr", 32'(ramRaddrA), 32'h0);
        req = 3'b111;
        #1;
        checkOutput("reset ready with req", 32'(readyA), 32'h0);
        stepTo();
        checkOutput("reset ready after edge", 32'(readyA), 32'h0);
        req = '0;
        stepTo();
        reset_n = 1'b1;

        // Idle grant latency
        applyStimulus(1, 1'b1, 11'h123, 1'b0, 8'h00);
        #1;
        checkOutput("s1 idle ready", 32'(readyA), 32'h0);
        stepTo();
        checkOutput("s1 setup ready", 32'(readyA), 32'h0);
        checkOutput("s1 setup raddr", 32'(ramRaddrA), 32'h0);
        stepTo();
        checkOutput("s1 own ready", 32'(readyA), 32'h2);
        checkOutput("s1 own raddr", 32'(ramRaddrA), 32'h123);
        checkOutput("s1 own we", 32'(ramWeA), 32'h0);
        stepTo();
        checkOutput("s1 read data", 32'(rdataA), 32'(memInit(11'h123)));
        applyStimulus(1, 1'b0, 11'h123, 1'b0, 8'h00);
        #1;
        checkOutput("s1 drop ready", 32'(readyA), 32'h0);
        stepTo();
        checkOutput("s1 idle again", 32'(readyA), 32'h0);

        // Pre-emption by port 0 and stall-transparent regain
        applyStimulus(1, 1'b1, 11'h010, 1'b0, 8'h00);
        stepTo();
        checkOutput("s2 setup raddr last", 32'(ramRaddrA), 32'h123);
        stepTo();
        checkOutput("s2 own ready", 32'(readyA), 32'h2);
        checkOutput("s2 transparent rdata", 32'(rdataA), 32'(memInit(11'h123)));
        applyStimulus(0, 1'b1, 11'h055, 1'b0, 8'h00);
        #1;
        checkOutput("s2 preempt completes", 32'(readyA), 32'h2);
        stepTo();
        checkOutput("s2 preempt setup ready", 32'(readyA), 32'h0);
        checkOutput("s2 preempt setup raddr", 32'(ramRaddrA), 32'h0);
        stepTo();
        checkOutput("s2 port0 ready", 32'(readyA), 32'h1);
        checkOutput("s2 port0 raddr", 32'(ramRaddrA), 32'h055);
        applyStimulus(1, 1'b1, 11'h020, 1'b0, 8'h00);
        stepTo();
        applyStimulus(0, 1'b0, 11'h055, 1'b0, 8'h00);
        #1;
        checkOutput("s2 release ready", 32'(readyA), 32'h0);
        checkOutput("s2 release we", 32'(ramWeA), 32'h0);
        stepTo();
        checkOutput("s2 regain setup raddr", 32'(ramRaddrA), 32'h010);
        stepTo();
        checkOutput("s2 regain ready", 32'(readyA), 32'h2);
        checkOutput("s2 regain rdata", 32'(rdataA), 32'(memInit(11'h010)));
        applyStimulus(1, 1'b0, 11'h020, 1'b0, 8'h00);

        // Hold limit alternation between ports 1 and 2
        doReset();
        applyStimulus(1, 1'b1, 11'h001, 1'b0, 8'h00);
        applyStimulus(2, 1'b1, 11'h002, 1'b0, 8'h00);
        #1;
        checkOutput("s3 start ready", 32'(readyA), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            stepTo();
            if ((k - 1) % 5 == 0) begin
                expReady = 32'h0;
            end else if (((k - 1) / 5) % 2 == 0) begin
                expReady = 32'h2;
            end else begin
                expReady = 32'h4;
            end
            checkOutput($sformatf("s3 hold cycle %0d", k), 32'(readyA), expReady);
        end
        req = '0;
        stepTo();

        // Single write pulse with we held through SETUP, then read back
        applyStimulus(2, 1'b1, 11'h7FF, 1'b1, 8'hA5);
        weSeen = 0;
        #1;
        weSeen += int'(ramWeA);
        stepTo();
        checkOutput("s4 no write in setup", 32'(ramWeA), 32'h0);
        weSeen += int'(ramWeA);
        stepTo();
        checkOutput("s4 own we", 32'(ramWeA), 32'h1);
        checkOutput("s4 own waddr", 32'(ramWaddrA), 32'h7FF);
        checkOutput("s4 own wdata", 32'(ramWdataA), 32'hA5);
        weSeen += int'(ramWeA);
        stepTo();
        applyStimulus(2, 1'b0, 11'h7FF, 1'b0, 8'hA5);
        #1;
        weSeen += int'(ramWeA);
        checkOutput("s4 we pulse count", 32'(weSeen), 32'd1);
        stepTo();
        applyStimulus(1, 1'b1, 11'h7FF, 1'b0, 8'h00);
        stepTo();
        stepTo();
        stepTo();
        checkOutput("s4 readback", 32'(rdataA), 32'hA5);
        applyStimulus(1, 1'b0, 11'h7FF, 1'b0, 8'h00);
        stepTo();

        // Reset asserted in the middle of a write
        applyStimulus(2, 1'b1, 11'h100, 1'b1, 8'h3C);
        stepTo();
        stepTo();
        checkOutput("s5 own we", 32'(ramWeA), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("s5 reset we", 32'(ramWeA), 32'h0);
        checkOutput("s5 reset ready", 32'(readyA), 32'h0);
        checkOutput("s5 reset raddr", 32'(ramRaddrA), 32'h0);
        checkOutput("s5 reset waddr", 32'(ramWaddrA), 32'h0);
        stepTo();
        checkOutput("s5 held in reset", 32'(readyA), 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("s5 released ready", 32'(readyA), 32'h0);
        stepTo();
        checkOutput("s5 setup raddr cleared", 32'(ramRaddrA), 32'h0);
        stepTo();
        checkOutput("s5 regrant ready", 32'(readyA), 32'h4);
        req = '0;
        we  = '0;

        // No pre-emption: port 1 keeps the grant until it lets go
        doReset();
        applyStimulus(1, 1'b1, 11'h040, 1'b0, 8'h00);
        stepTo();
        checkOutput("s6 setup ready", 32'(readyB), 32'h0);
        stepTo();
        checkOutput("s6 own ready", 32'(readyB), 32'h2);
        applyStimulus(0, 1'b1, 11'h050, 1'b0, 8'h00);
        #1;
        checkOutput("s6 no preempt", 32'(readyB), 32'h2);
        for (int k = 0; k < 3; k++) begin
            stepTo();
            checkOutput($sformatf("s6 keeps grant %0d", k), 32'(readyB), 32'h2);
        end
        applyStimulus(1, 1'b0, 11'h040, 1'b0, 8'h00);
        #1;
        checkOutput("s6 release ready", 32'(readyB), 32'h0);
        stepTo();
        checkOutput("s6 port0 setup", 32'(readyB), 32'h0);
        stepTo();
        checkOutput("s6 port0 ready", 32'(readyB), 32'h1);
        req = '0;
        stepTo();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
